// File: rtl/apb_pkg.sv
// Shared types and sizes for the APB master and its wait timer.
package apb_pkg;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_cmd_t;
endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter; flags the TIMEOUT-th stalled cycle.
module apb_wait_timer import apb_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SAT   = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                    cnt_d = '0;
    else if (inc && cnt_q != SAT) cnt_d = cnt_q + 1'b1;
  end

  // cnt_q counts stalled cycles already seen, so LIMIT marks the TIMEOUT-th one.
  assign expired = inc && (cnt_q == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/apb_master.sv
// APB master: one command at a time, registered bus and response outputs.
module apb_master import apb_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PRWADDR,
  output logic [DATA_W-1:0] PRWDATA,
  input  logic [DATA_W-1:0] PRWDATA1,
  input  logic              PREADY
);
  state_e            state_q, state_d;
  apb_cmd_t          bus_q, bus_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              tmr_clr, tmr_inc, tmr_expired;

  assign tmr_inc = (state_q == ACCESS) && !PREADY;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (PCLK),
    .rst     (PRESET),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    bus_d       = bus_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    tmr_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_addr[1:0] == 2'b00) begin
            bus_d   = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
            state_d = SETUP;
            psel_d  = 1'b1;
            tmr_clr = 1'b1;
          end else begin
            // Misaligned: answer immediately with an error, bus untouched.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus_q.write ? '0 : PRWDATA1;
        end else if (tmr_expired) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      bus_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_q       <= bus_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = bus_q.write;
  assign PRWADDR   = bus_q.addr;
  assign PRWDATA   = bus_q.wdata;
endmodule

// File: tb/tb_apb_master.sv
// Scoreboarded bench for apb_master with a wait-state programmable slave.
module tb_apb_master;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        PCLK, PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  logic [31:0] PRWADDR, PRWDATA, PRWDATA1;

  apb_master #(.TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PRWADDR(PRWADDR), .PRWDATA(PRWDATA), .PRWDATA1(PRWDATA1), .PREADY(PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  exp_t sb[$];
  int   total = 0, bad = 0, nrsp = 0;
  bit   mon_en = 1'b0;
  int   slv_wait = 0;
  bit   slv_stall = 1'b0;

  // Slave read data is a fixed function of the address the bench issued.
  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a + 32'd3;
  endfunction

  // Slave: raises PREADY after slv_wait ACCESS cycles, never when stalled.
  initial begin
    int acc_cnt;
    acc_cnt  = 0;
    PREADY   = 1'b0;
    PRWDATA1 = '0;
    forever begin
      @(posedge PCLK);
      #1;
      if (PSEL && PENABLE) begin
        PREADY   = !slv_stall && (acc_cnt >= slv_wait);
        PRWDATA1 = PREADY ? rd_of(PRWADDR) : 32'hDEAD_BEEF;
        acc_cnt++;
      end else begin
        PREADY  = 1'b0;
        acc_cnt = 0;
      end
    end
  end

  // Monitor: response scoreboard and bus protocol stability.
  initial begin
    exp_t        e;
    logic        prev_rsp, prev_psel, prev_wr;
    logic [31:0] prev_addr, prev_wdata;
    prev_rsp = 0; prev_psel = 0; prev_wr = 0; prev_addr = 0; prev_wdata = 0;
    forever begin
      @(negedge PCLK);
      if (mon_en) begin
        if (rsp_valid) begin
          nrsp++;
          total++;
          if (prev_rsp) begin
            bad++; $display("FAIL rsp_single_pulse: rsp_valid high two cycles in a row");
          end
          total++;
          if (sb.size() == 0) begin
            bad++; $display("FAIL rsp_unexpected: rsp_valid=1 err=%0b with no command pending", rsp_err);
          end else begin
            e = sb.pop_front();
            if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
              bad++;
              $display("FAIL rsp_payload: got err=%0b rdata=%h, want err=%0b rdata=%h",
                       rsp_err, rsp_rdata, e.err, e.rdata);
            end
          end
        end
        if (PENABLE) begin
          total++;
          if (!PSEL || !prev_psel) begin
            bad++; $display("FAIL access_order: PENABLE=1 with PSEL=%0b prev_psel=%0b", PSEL, prev_psel);
          end
        end
        if (PSEL && prev_psel) begin
          total++;
          if (PRWADDR !== prev_addr || PRWDATA !== prev_wdata || PWRITE !== prev_wr) begin
            bad++;
            $display("FAIL bus_stable: addr %h->%h data %h->%h wr %0b->%0b",
                     prev_addr, PRWADDR, prev_wdata, PRWDATA, prev_wr, PWRITE);
          end
        end
      end
      prev_rsp = rsp_valid; prev_psel = PSEL; prev_wr = PWRITE;
      prev_addr = PRWADDR; prev_wdata = PRWDATA;
    end
  end

  // Issues one command; returns just after its accepting edge.
  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic e_err, input logic [31:0] e_rd);
    exp_t e;
    bit   ok;
    ok = 0;
    e.err = e_err; e.rdata = e_rd;
    @(posedge PCLK); #1;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge PCLK);
      @(posedge PCLK);
      if (cmd_ready) begin
        sb.push_back(e);
        ok = 1;
      end
    end
    #1 cmd_valid = 1'b0;
    if (!ok) begin
      $display("FAIL cmd_accept: cmd_ready never seen for addr %h", a);
      $fatal(1, "command not accepted");
    end
  endtask

  // Counts negedges from acceptance until rsp_valid (cyc=-1 if it never comes).
  task automatic run_until_rsp(output int cyc, output int psel_n, output int en_n);
    cyc = -1; psel_n = 0; en_n = 0;
    for (int i = 1; i <= 200 && cyc < 0; i++) begin
      @(negedge PCLK);
      if (PSEL)      psel_n++;
      if (PENABLE)   en_n++;
      if (rsp_valid) cyc = i;
    end
  endtask

  task automatic test_reset;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    total++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: psel/en/wr/rv/err/rdy=%b want 000000",
                      {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready});
    end
    total++;
    if (PRWADDR !== 0 || PRWDATA !== 0 || rsp_rdata !== 0) begin
      bad++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0", PRWADDR, PRWDATA, rsp_rdata);
    end
    @(negedge PCLK);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready_rise: cmd_ready=%b want 1", cmd_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_write;
    int cyc, ps, en;
    slv_wait = 1; slv_stall = 0;
    send_cmd(1'b1, 32'h4, 32'h3, 1'b0, 32'h0);
    run_until_rsp(cyc, ps, en);
    total++;
    if (cyc != 4 || ps != 3) begin
      bad++; $display("FAIL write_timing: rsp at %0d psel cycles %0d, want 4 and 3", cyc, ps);
    end
    total++;
    if (rsp_err !== 1'b0 || PRWDATA !== 32'h3 || PRWADDR !== 32'h4 || PWRITE !== 1'b1) begin
      bad++; $display("FAIL write_hold: err=%b data=%h addr=%h wr=%b want 0/3/4/1",
                      rsp_err, PRWDATA, PRWADDR, PWRITE);
    end
  endtask

  task automatic test_read;
    int cyc, ps, en;
    slv_wait = 2; slv_stall = 0;
    send_cmd(1'b0, 32'h4, 32'hFFFF_0000, 1'b0, 32'h7);
    run_until_rsp(cyc, ps, en);
    total++;
    if (cyc < 0 || rsp_rdata !== 32'h7 || rsp_err !== 1'b0 || en != 3) begin
      bad++; $display("FAIL read_data: cyc=%0d rdata=%h err=%b access=%0d want 7/0/3",
                      cyc, rsp_rdata, rsp_err, en);
    end
  endtask

  task automatic test_timeout;
    int cyc, ps, en;
    slv_stall = 1;
    send_cmd(1'b0, 32'h8, 32'h0, 1'b1, 32'h0);
    run_until_rsp(cyc, ps, en);
    total++;
    if (cyc < 0 || en != 16 || rsp_err !== 1'b1 || rsp_rdata !== 0 || PSEL !== 1'b0) begin
      bad++; $display("FAIL timeout: cyc=%0d access=%0d err=%b rdata=%h psel=%b want 16/1/0/0",
                      cyc, en, rsp_err, rsp_rdata, PSEL);
    end
    slv_stall = 0;
  endtask

  task automatic test_timeout_edge;
    int cyc, ps, en;
    slv_wait = 15;
    send_cmd(1'b0, 32'h20, 32'h0, 1'b0, rd_of(32'h20));
    run_until_rsp(cyc, ps, en);
    total++;
    if (cyc < 0 || en != 16 || rsp_err !== 1'b0 || rsp_rdata !== rd_of(32'h20)) begin
      bad++; $display("FAIL ready_at_limit: access=%0d err=%b rdata=%h want 16/0/%h",
                      en, rsp_err, rsp_rdata, rd_of(32'h20));
    end
    slv_wait = 16;
    send_cmd(1'b1, 32'h24, 32'h55, 1'b1, 32'h0);
    run_until_rsp(cyc, ps, en);
    total++;
    if (cyc < 0 || en != 16 || rsp_err !== 1'b1) begin
      bad++; $display("FAIL ready_after_limit: access=%0d err=%b want 16/1", en, rsp_err);
    end
  endtask

  task automatic test_misaligned;
    int ps;
    ps = 0;
    send_cmd(1'b0, 32'h6, 32'h0, 1'b1, 32'h0);
    @(negedge PCLK);
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL misaligned_rsp: rv=%b err=%b rdata=%h rdy=%b want 1/1/0/1",
                      rsp_valid, rsp_err, rsp_rdata, cmd_ready);
    end
    send_cmd(1'b1, 32'h7, 32'h9, 1'b1, 32'h0);
    repeat (4) begin
      @(negedge PCLK);
      if (PSEL) ps++;
    end
    total++;
    if (ps != 0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL misaligned_nobus: psel cycles=%0d rdy=%b want 0/1", ps, cmd_ready);
    end
  endtask

  task automatic test_reset_mid;
    int  base;
    bit  seen;
    seen = 0;
    slv_stall = 1;
    send_cmd(1'b0, 32'hC, 32'h0, 1'b1, 32'h0);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge PCLK);
      seen = PENABLE;
    end
    base = nrsp;
    PRESET = 1'b1;
    @(posedge PCLK);
    #1 PRESET = 1'b0;
    sb.delete();
    @(negedge PCLK);
    total++;
    if (!seen || PSEL !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL reset_mid_edge: seen=%b psel=%b rv=%b rdy=%b want 1/0/0/0",
                      seen, PSEL, rsp_valid, cmd_ready);
    end
    @(negedge PCLK);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid_ready: cmd_ready=%b want 1", cmd_ready);
    end
    slv_stall = 0;
    repeat (20) @(negedge PCLK);
    total++;
    if (nrsp != base) begin
      bad++; $display("FAIL reset_mid_norsp: %0d responses after reset want 0", nrsp - base);
    end
  endtask

  task automatic test_back_to_back;
    int   base, n;
    exp_t e;
    base = nrsp; n = 0;
    slv_wait = 0;
    @(posedge PCLK); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge PCLK);
      @(posedge PCLK);
      if (cmd_ready) begin
        e.err = 1'b0; e.rdata = rd_of(cmd_addr);
        sb.push_back(e);
        n++;
        #1 cmd_addr = 32'h10 + 32'(4 * n);
        if (n == 3) cmd_valid = 1'b0;
      end
    end
    repeat (10) @(negedge PCLK);
    total++;
    if (n != 3 || nrsp - base != 3) begin
      bad++; $display("FAIL back_to_back: accepted=%0d responses=%0d want 3/3", n, nrsp - base);
    end
  endtask

  initial begin
    PRESET = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_timeout_edge();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge PCLK);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drain: %0d expected responses never arrived", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
